cache_write_through_buffer: RTL and testbench
=============================================

Name: cache_write_through_buffer

Overview:
- Synchronous FIFO between the cache front end (write-through hits and misses) and the AXI write channel.
- It decouples front-end stores from AXI write latency.
- Output data is registered. A pop loads the head entry into the output registers, and those registers hold until the next pop. This lets the write channel use addr/wdata/wstrb combinationally for a whole AW/W/B transaction.
- It also exposes an empty/occupancy status. The cache controller uses it to order reads after outstanding writes.

Parameters:
- CACHE_FRONTEND_ADDR_W, 32, front-end byte-address width.
- CACHE_FRONTEND_DATA_W, 32, front-end word width; multiple of 8.
- CACHE_FRONTEND_NBYTES, CACHE_FRONTEND_DATA_W/8, strobe width.
- CACHE_FRONTEND_BYTE_W, $clog2(CACHE_FRONTEND_NBYTES), byte-offset bits dropped from the stored address.
- CACHE_WTBUF_DEPTH_W, 4, log2 of FIFO depth (depth = 16); legal range 1..8.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  front end presents a write.
- in_addr  in  CACHE_FRONTEND_ADDR_W-CACHE_FRONTEND_BYTE_W  word address, bits [ADDR_W-1:BYTE_W].
- in_wdata  in  CACHE_FRONTEND_DATA_W  write data.
- in_wstrb  in  CACHE_FRONTEND_NBYTES  byte enables.
- in_ready  out  1  = ~full; a push occurs on in_valid & in_ready.
- mem_valid  out  1  = ~empty; entries are waiting to be loaded.
- mem_addr  out  same as in_addr  registered head address.
- mem_wdata  out  CACHE_FRONTEND_DATA_W  registered head data.
- mem_wstrb  out  CACHE_FRONTEND_NBYTES  registered head strobes.
- mem_ready  in  1  write channel ready; a pop occurs on mem_ready & mem_valid.
- empty  out  1  no stored entries (level = 0).
- full  out  1  level = 2**CACHE_WTBUF_DEPTH_W.
- level  out  CACHE_WTBUF_DEPTH_W+1  current entry count, 0..depth.

Behaviour:
- Storage: depth x (addr+data+strb) register array. Write pointer and read pointer are each CACHE_WTBUF_DEPTH_W bits and wrap modulo depth. level is a separate up/down counter.
- Flag derivation: full, empty and in_ready are derived from the registered level only, never from same-cycle mem_ready.
- Reset (synchronous, ap_clk edge with reset=1):
  - wptr, rptr and level go to 0, so empty=1, full=0, in_ready=1, mem_valid=0.
  - mem_addr, mem_wdata and mem_wstrb go to 0.
  - Storage array is not reset.
  - Reset mid-operation discards all entries and any in-progress output, and takes priority over push and pop that cycle.
- Push (in_valid & ~full): store at wptr; wptr+1; level+1 unless a pop occurs in the same cycle.
- Pop (mem_ready & ~empty):
  - mem_* registers load the entry at rptr on that edge, so new values appear the next cycle.
  - rptr+1; level-1 unless a push occurs in the same cycle.
  - Latency from push to mem_* output is at least 2 cycles: push edge, then pop edge.
- mem_* hold: mem_* hold their value whenever no pop occurs. mem_ready with empty=1 changes nothing.
- Simultaneous push and pop, 0 < level < depth: both happen; level unchanged; pointers both advance.
- Empty + push: level becomes 1. A pop is impossible that cycle because mem_valid was 0. No bypass.
- Full: in_ready=0, and a push attempt is ignored even if a pop occurs the same cycle. in_ready rises the cycle after the pop.
- Level = depth-1 with push and no pop: full next cycle.
- Pointer wrap: wptr/rptr roll from depth-1 to 0 with no bubble.
- Ordering: strict FIFO; entries pop in push order.
- No error or overflow state: front-end writes with in_ready=0 are the caller's responsibility to hold.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> empty=1, full=0, level=0, in_ready=1, mem_valid=0, mem_addr/wdata/wstrb=0. mem_ready=1 held for 5 cycles -> no change.
- Single write: push addr=0x1234, wdata=0xDEADBEEF, wstrb=4'b0011 with mem_ready=0 -> next cycle level=1, mem_valid=1, mem_* still 0. Pulse mem_ready one cycle -> next cycle mem_addr=0x1234, mem_wdata=0xDEADBEEF, mem_wstrb=4'b0011, level=0. These hold for 10 cycles.
- Fill/overflow (depth 16): push 17 writes (data=i) with mem_ready=0 -> level=16, full=1, in_ready=0 after the 16th push; the 17th is not stored. Then drain with mem_ready=1 -> mem_wdata sequence 0..15, then empty=1.
- Full with simultaneous attempts: at level=16, in_valid=1 and mem_ready=1 together -> pop only; level=15; in_ready=1 the next cycle; the following push is accepted.
- Streaming wrap: mem_ready=1 continuously and 40 back-to-back pushes -> level never exceeds 1. Output data matches push order across pointer wrap (indices 15 to 0, twice).
- Reset mid-operation: level=5, assert reset with in_valid=1 and mem_ready=1 -> next cycle level=0 and mem_*=0. No entry from before reset ever appears on mem_*.

Source files
------------

// File: rtl/cache_write_through_buffer.sv
// cache_write_through_buffer: write-through store FIFO with registered head output for the AXI write channel
module cache_write_through_buffer #(
  parameter int CACHE_FRONTEND_ADDR_W = 32,
  parameter int CACHE_FRONTEND_DATA_W = 32,
  parameter int CACHE_FRONTEND_NBYTES = CACHE_FRONTEND_DATA_W / 8,
  parameter int CACHE_FRONTEND_BYTE_W = $clog2(CACHE_FRONTEND_NBYTES),
  parameter int CACHE_WTBUF_DEPTH_W   = 4
) (
  input  logic                                              ap_clk,
  input  logic                                              reset,
  input  logic                                              in_valid,
  input  logic [CACHE_FRONTEND_ADDR_W-CACHE_FRONTEND_BYTE_W-1:0] in_addr,
  input  logic [CACHE_FRONTEND_DATA_W-1:0]                  in_wdata,
  input  logic [CACHE_FRONTEND_NBYTES-1:0]                  in_wstrb,
  output logic                                              in_ready,
  output logic                                              mem_valid,
  output logic [CACHE_FRONTEND_ADDR_W-CACHE_FRONTEND_BYTE_W-1:0] mem_addr,
  output logic [CACHE_FRONTEND_DATA_W-1:0]                  mem_wdata,
  output logic [CACHE_FRONTEND_NBYTES-1:0]                  mem_wstrb,
  input  logic                                              mem_ready,
  output logic                                              empty,
  output logic                                              full,
  output logic [CACHE_WTBUF_DEPTH_W:0]                      level
);
  localparam int DW = CACHE_WTBUF_DEPTH_W;
  localparam int DEPTH = 1 << DW;
  localparam int EW = CACHE_FRONTEND_ADDR_W - CACHE_FRONTEND_BYTE_W + CACHE_FRONTEND_DATA_W + CACHE_FRONTEND_NBYTES;
  logic [EW-1:0] store_q [DEPTH];
  logic [EW-1:0] out_q, out_d;
  logic [DW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DW:0]   level_q, level_d;
  logic          push, pop;
  assign full      = level_q == (DW+1)'(DEPTH);
  assign empty     = level_q == '0;
  assign in_ready  = ~full;
  assign mem_valid = ~empty;
  assign level     = level_q;
  assign {mem_addr, mem_wdata, mem_wstrb} = out_q;
  // Flags come from the registered level only, so a full buffer rejects a push even when it pops.
  always_comb begin
    push    = in_valid & ~full;
    pop     = mem_ready & ~empty;
    wptr_d  = wptr_q + DW'(push);
    rptr_d  = rptr_q + DW'(pop);
    level_d = level_q + (DW+1)'(push) - (DW+1)'(pop);
    out_d   = pop ? store_q[rptr_q] : out_q;
  end
  always_ff @(posedge ap_clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      out_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      out_q   <= out_d;
    end
  end
  always_ff @(posedge ap_clk) begin
    if (!reset && push) store_q[wptr_q] <= {in_addr, in_wdata, in_wstrb};
  end
endmodule

// File: tb/tb_cache_write_through_buffer.sv
// tb_cache_write_through_buffer: table vectors, directed corner sequences and random traffic against a queue model
module tb_cache_write_through_buffer;
  logic        ap_clk = 0;
  logic        reset, in_valid, mem_ready;
  logic [29:0] in_addr;
  logic [31:0] in_wdata;
  logic [3:0]  in_wstrb;
  logic        in_ready, mem_valid, empty, full;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [4:0]  level;
  int checks = 0;
  int errors = 0;

  cache_write_through_buffer dut (
    .ap_clk(ap_clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_ready(in_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .empty(empty), .full(full),
    .level(level)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;
  ent_t q[$];
  ent_t eo = '0;

  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, act, exp);
    end
  endfunction

  task automatic drive(bit r, bit v, logic [29:0] a, logic [31:0] d, logic [3:0] s, bit rd);
    reset = r; in_valid = v; in_addr = a; in_wdata = d; in_wstrb = s; mem_ready = rd;
  endtask

  // FIFO of 16 entries with a separately held output word; capacity is judged before the edge
  task automatic tick();
    bit pu, po;
    ent_t e;
    e  = '{in_addr, in_wdata, in_wstrb};
    pu = in_valid && q.size() < 16;
    po = mem_ready && q.size() > 0;
    @(posedge ap_clk);
    #1;
    if (reset) begin
      q.delete();
      eo = '0;
    end else begin
      if (po) eo = q.pop_front();
      if (pu) q.push_back(e);
    end
    chk("level", level, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == 16);
    chk("in_ready", in_ready, q.size() != 16);
    chk("mem_valid", mem_valid, q.size() != 0);
    chk("mem_addr", mem_addr, eo.a);
    chk("mem_wdata", mem_wdata, eo.d);
    chk("mem_wstrb", mem_wstrb, eo.s);
  endtask

  typedef struct {
    bit          r, v, rd;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          lvl;
    bit          emp;
    logic [29:0] ea;
    logic [31:0] ed;
    logic [3:0]  es;
  } vec_t;
  vec_t tbl[$];

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    tbl = '{
      '{1, 0, 0, 30'h0,    32'h0,        4'h0, 0, 1, 30'h0,    32'h0,        4'h0},
      '{1, 0, 0, 30'h0,    32'h0,        4'h0, 0, 1, 30'h0,    32'h0,        4'h0},
      '{0, 0, 1, 30'h0,    32'h0,        4'h0, 0, 1, 30'h0,    32'h0,        4'h0},
      '{0, 0, 1, 30'h0,    32'h0,        4'h0, 0, 1, 30'h0,    32'h0,        4'h0},
      '{0, 0, 1, 30'h0,    32'h0,        4'h0, 0, 1, 30'h0,    32'h0,        4'h0},
      '{0, 0, 1, 30'h0,    32'h0,        4'h0, 0, 1, 30'h0,    32'h0,        4'h0},
      '{0, 0, 1, 30'h0,    32'h0,        4'h0, 0, 1, 30'h0,    32'h0,        4'h0},
      '{0, 1, 0, 30'h1234, 32'hDEADBEEF, 4'h3, 1, 0, 30'h0,    32'h0,        4'h0},
      '{0, 0, 1, 30'h0,    32'h0,        4'h0, 0, 1, 30'h1234, 32'hDEADBEEF, 4'h3},
      '{0, 0, 0, 30'h0,    32'h0,        4'h0, 0, 1, 30'h1234, 32'hDEADBEEF, 4'h3},
      '{0, 0, 1, 30'h0,    32'h0,        4'h0, 0, 1, 30'h1234, 32'hDEADBEEF, 4'h3},
      '{0, 1, 1, 30'h77,   32'h5,        4'hF, 1, 0, 30'h1234, 32'hDEADBEEF, 4'h3},
      '{0, 1, 1, 30'h78,   32'h6,        4'h1, 1, 0, 30'h77,   32'h5,        4'hF},
      '{0, 0, 1, 30'h0,    32'h0,        4'h0, 0, 1, 30'h78,   32'h6,        4'h1}
    };
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].rd);
      tick();
      chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].emp);
      chk($sformatf("vec%0d_out", i), {mem_addr, mem_wdata, mem_wstrb}, {tbl[i].ea, tbl[i].ed, tbl[i].es});
    end
    // Hold check: outputs stay put with no pop
    drive(0, 0, 0, 0, 0, 0);
    repeat (10) tick();
    chk("hold_wdata", mem_wdata, 32'h6);

    // Fill past capacity: the 17th push must be dropped
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, 30'(i + 16'h100), 32'(i), 4'hF, 0);
      tick();
      if (i == 15) chk("fill_full", {full, in_ready, level}, {1'b1, 1'b0, 5'd16});
    end
    chk("overflow_level", level, 16);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_order", mem_wdata, i);
    end
    chk("drain_empty", empty, 1);

    // Full with push and pop together: only the pop happens
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 30'(i), 32'(32'h200 + i), 4'h2, 0);
      tick();
    end
    drive(0, 1, 30'h3FF, 32'hBAD, 4'h8, 1);
    tick();
    chk("fullpp_level", level, 15);
    chk("fullpp_ready", in_ready, 1);
    chk("fullpp_out", mem_wdata, 32'h200);
    drive(0, 1, 30'h3FE, 32'h600D, 4'h4, 0);
    tick();
    chk("fullpp_push", level, 16);
    drive(0, 0, 0, 0, 0, 1);
    repeat (16) tick();
    chk("fullpp_tail", mem_wdata, 32'h600D);

    // Streaming across pointer wrap
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, 30'(i), 32'(32'h1000 + i), 4'(i), 1);
      tick();
      chk("stream_level", level <= 1, 1);
      if (i > 0) chk("stream_data", mem_wdata, 32'h1000 + i - 1);
    end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("stream_last", mem_wdata, 32'h1000 + 39);

    // Reset mid-operation wins over push and pop
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 30'(i), 32'(32'hA000 + i), 4'hF, 0);
      tick();
    end
    chk("pre_reset_level", level, 5);
    drive(1, 1, 30'h1, 32'hFFFF, 4'hF, 1);
    tick();
    chk("reset_level", level, 0);
    chk("reset_out", {mem_addr, mem_wdata, mem_wstrb}, 66'h0);
    drive(0, 1, 30'h2A, 32'hC0DE, 4'h5, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    chk("post_reset_data", mem_wdata, 32'hC0DE);

    // Random traffic with phase-varying pressure so both full and empty are visited
    for (int i = 0; i < 4000; i++) begin
      int pv, pr;
      pv = ((i / 250) % 2 == 0) ? 80 : 30;
      pr = ((i / 250) % 2 == 0) ? 30 : 80;
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 99) < pv, 30'($urandom),
            $urandom, 4'($urandom), $urandom_range(0, 99) < pr);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
